// File: rtl/hyperram_arb_pkg.sv
// hyperram_arb_pkg
//   Shared types and constants for the HyperRAM request arbiter.
//   Optional feature macro: HYPERRAM_ARB_PRIO0_EN (fixed top priority for port 0,
//   consumed inside hyperram_rr_picker).
//   No ports (package).
package hyperram_arb_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 16;
  localparam int DS_W      = 2;
  localparam int MAX_PORTS = 4;
  localparam int GRANT_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hyperram_rr_picker.sv
// hyperram_rr_picker
//   Combinational round-robin selector. Scans pending requesters starting at
//   rr_ptr and wrapping modulo NUM_PORTS; the first pending port wins.
//   With HYPERRAM_ARB_PRIO0_EN defined, port 0 always wins when pending and the
//   remaining ports rotate among themselves.
// Ports:
//   pending [NUM_PORTS]  in   per-port pending flags
//   rr_ptr  [GRANT_W]    in   port that gets priority next
//   valid                out  at least one port is pending
//   index   [GRANT_W]    out  selected port (only meaningful when valid)
module hyperram_rr_picker
  import hyperram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [GRANT_W-1:0]   rr_ptr,
  output logic                 valid,
  output logic [GRANT_W-1:0]   index
);

  // Zero-extended copy so a 2-bit candidate index is always in range.
  logic [MAX_PORTS-1:0] pending_ext;
  assign pending_ext = MAX_PORTS'(pending);

  always_comb begin
    int                 cand;
    logic [GRANT_W-1:0] cand_idx;
    valid    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
`ifdef HYPERRAM_ARB_PRIO0_EN
    if (pending_ext[0]) begin
      valid = 1'b1;
      index = '0;
    end else begin
      // Rotation over ports 1..NUM_PORTS-1; rr_ptr==0 means start at port 1.
      for (int k = 0; k < NUM_PORTS - 1; k++) begin
        cand     = 1 + (((rr_ptr == '0) ? 0 : (int'(rr_ptr) - 1)) + k) % (NUM_PORTS - 1);
        cand_idx = GRANT_W'(cand);
        if (!valid && pending_ext[cand_idx]) begin
          valid = 1'b1;
          index = cand_idx;
        end
      end
    end
`else
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand     = (int'(rr_ptr) + k) % NUM_PORTS;
      cand_idx = GRANT_W'(cand);
      if (!valid && pending_ext[cand_idx]) begin
        valid = 1'b1;
        index = cand_idx;
      end
    end
`endif
  end

endmodule

// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter
//   Shares one HyperRAM controller toggle req/ack interface between NUM_PORTS
//   requesters, one transaction at a time, round-robin.
//   Optional feature macro: HYPERRAM_ARB_PRIO0_EN (port 0 fixed top priority;
//   rr_ptr is not advanced after a port-0 grant).
// Ports:
//   clk, reset (async, active high)
//   p_req/p_ack          per-port toggle handshake (pending when they differ)
//   p_as/p_we/p_linear_burst/p_a/p_d/p_ds  per-port request fields (flattened)
//   p_q                  per-port read data holding registers (flattened)
//   m_req/m_ack          toggle handshake to the controller
//   m_as/m_we/m_linear_burst/m_a/m_d/m_ds  forwarded fields, m_q read data
//   grant                port currently or last served
//   busy                 high while a transaction is outstanding downstream
module hyperram_arbiter
  import hyperram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        p_req,
  output logic [NUM_PORTS-1:0]        p_ack,
  input  logic [NUM_PORTS-1:0]        p_as,
  input  logic [NUM_PORTS-1:0]        p_we,
  input  logic [NUM_PORTS-1:0]        p_linear_burst,
  input  logic [ADDR_W*NUM_PORTS-1:0] p_a,
  input  logic [DATA_W*NUM_PORTS-1:0] p_d,
  input  logic [DS_W*NUM_PORTS-1:0]   p_ds,
  output logic [DATA_W*NUM_PORTS-1:0] p_q,
  output logic                        m_req,
  input  logic                        m_ack,
  output logic                        m_as,
  output logic                        m_we,
  output logic                        m_linear_burst,
  output logic [ADDR_W-1:0]           m_a,
  output logic [DATA_W-1:0]           m_d,
  output logic [DS_W-1:0]             m_ds,
  input  logic [DATA_W-1:0]           m_q,
  output logic [GRANT_W-1:0]          grant,
  output logic                        busy
);

  arb_state_t state_reg, state_next;

  logic [NUM_PORTS-1:0]        p_ack_reg;
  logic [DATA_W*NUM_PORTS-1:0] p_q_reg;
  logic [GRANT_W-1:0]          grant_reg, rr_ptr_reg;
  logic                        busy_reg, m_req_reg;
  logic                        m_as_reg, m_we_reg, m_lb_reg;
  logic [ADDR_W-1:0]           m_a_reg;
  logic [DATA_W-1:0]           m_d_reg;
  logic [DS_W-1:0]             m_ds_reg;

  logic                        pick_valid;
  logic [GRANT_W-1:0]          pick_index;
  logic                        load, capture, finish;

  // Per-port fields padded to MAX_PORTS so a 2-bit index always selects in range.
  logic [MAX_PORTS-1:0] port_as, port_we, port_lb;
  logic [ADDR_W-1:0]    port_a  [MAX_PORTS];
  logic [DATA_W-1:0]    port_d  [MAX_PORTS];
  logic [DS_W-1:0]      port_ds [MAX_PORTS];

  assign port_as = MAX_PORTS'(p_as);
  assign port_we = MAX_PORTS'(p_we);
  assign port_lb = MAX_PORTS'(p_linear_burst);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PORTS; gi++) begin : g_port
      if (gi < NUM_PORTS) begin : g_used
        assign port_a[gi]  = p_a[ADDR_W*gi +: ADDR_W];
        assign port_d[gi]  = p_d[DATA_W*gi +: DATA_W];
        assign port_ds[gi] = p_ds[DS_W*gi +: DS_W];
      end else begin : g_unused
        assign port_a[gi]  = '0;
        assign port_d[gi]  = '0;
        assign port_ds[gi] = '0;
      end
    end
  endgenerate

  hyperram_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .pending (p_req ^ p_ack_reg),
    .rr_ptr  (rr_ptr_reg),
    .valid   (pick_valid),
    .index   (pick_index)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: if (pick_valid) begin
        load       = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (m_req_reg == m_ack) begin
        capture    = ~m_we_reg;
        state_next = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_ack_reg  <= '0;
      p_q_reg    <= '0;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      busy_reg   <= 1'b0;
      m_req_reg  <= 1'b0;
      m_as_reg   <= 1'b0;
      m_we_reg   <= 1'b0;
      m_lb_reg   <= 1'b0;
      m_a_reg    <= '0;
      m_d_reg    <= '0;
      m_ds_reg   <= '0;
    end else begin
      // Fields and the request toggle update on the same edge.
      if (load) begin
        m_as_reg  <= port_as[pick_index];
        m_we_reg  <= port_we[pick_index];
        m_lb_reg  <= port_lb[pick_index];
        m_a_reg   <= port_a[pick_index];
        m_d_reg   <= port_d[pick_index];
        m_ds_reg  <= port_ds[pick_index];
        grant_reg <= pick_index;
        m_req_reg <= ~m_req_reg;
        busy_reg  <= 1'b1;
      end
      if (capture) p_q_reg[grant_reg*DATA_W +: DATA_W] <= m_q;
      if (finish) begin
        p_ack_reg <= p_ack_reg ^ (NUM_PORTS'(1) << grant_reg);
        busy_reg  <= 1'b0;
`ifdef HYPERRAM_ARB_PRIO0_EN
        if (grant_reg != '0)
`endif
          rr_ptr_reg <= (int'(grant_reg) == NUM_PORTS - 1) ? '0 : grant_reg + 1'b1;
      end
    end
  end

  assign p_ack          = p_ack_reg;
  assign p_q            = p_q_reg;
  assign grant          = grant_reg;
  assign busy           = busy_reg;
  assign m_req          = m_req_reg;
  assign m_as           = m_as_reg;
  assign m_we           = m_we_reg;
  assign m_linear_burst = m_lb_reg;
  assign m_a            = m_a_reg;
  assign m_d            = m_d_reg;
  assign m_ds           = m_ds_reg;

endmodule

// File: doc/hyperram_arbiter.md
Name: hyperram_arbiter

Overview:
- Shares the single HyperRAM controller bus interface (toggle req/ack handshake, 32-bit address, 16-bit data) between NUM_PORTS requesters, e.g. REU DMA, CPU and debug.
- Each requester port uses the same toggle handshake as the controller. The arbiter serialises requests with round-robin grant and forwards one transaction at a time.
- Read data is returned into a per-port holding register.

Parameters:
- NUM_PORTS, 3, number of requester ports; legal range 2..4.

Ports:
- clk  in  1  system clock, shared with the HyperRAM controller.
- reset  in  1  asynchronous, active-high reset.
- p_req  in  NUM_PORTS  per-port toggle request; a port is pending when p_req[i] != p_ack[i].
- p_ack  out  NUM_PORTS  per-port toggle acknowledge.
- p_as  in  NUM_PORTS  per-port address-space select (register access).
- p_we  in  NUM_PORTS  per-port write enable.
- p_linear_burst  in  NUM_PORTS  per-port burst type.
- p_a  in  32*NUM_PORTS  per-port address; port i uses slice [32*i+31:32*i].
- p_d  in  16*NUM_PORTS  per-port write data.
- p_ds  in  2*NUM_PORTS  per-port byte strobes.
- p_q  out  16*NUM_PORTS  per-port read data holding register.
- m_req  out  1  toggle request to the controller.
- m_ack  in  1  toggle acknowledge from the controller.
- m_as, m_we, m_linear_burst  out  1 each  forwarded fields.
- m_a  out  32  forwarded address.
- m_d  out  16  forwarded write data.
- m_ds  out  2  forwarded byte strobes.
- m_q  in  16  controller read data.
- grant  out  2  index of the port currently or last served (debug).
- busy  out  1  high while a transaction is outstanding downstream.

Behaviour:
- Reset (asynchronous): all of the following clear to 0:
  - p_ack, p_q, m_req, m_as, m_we, m_linear_burst, m_a, m_d, m_ds, grant, busy.
  - rr_ptr (the port that gets priority next) clears to 0; state goes to IDLE.
- The controller and arbiter share reset, so m_req == m_ack == 0 after reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - pending[i] = p_req[i] ^ p_ack[i].
  - If any pending: pick the first pending port scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - In the next cycle: register that port's fields into the m_* outputs, set grant, toggle m_req, set busy=1, go to WAIT.
  - m_* fields and m_req update in the same edge, so the controller never sees a toggle with stale fields.
- WAIT:
  - Hold all m_* outputs stable.
  - When m_req == m_ack: if m_we==0, capture m_q into p_q slice [grant]; go to DONE.
- DONE:
  - Toggle p_ack[grant], clear busy, set rr_ptr = (grant+1) mod NUM_PORTS, go to IDLE.
  - p_q is valid no later than the edge that toggles p_ack.
- Latency:
  - Pending in IDLE at edge T → m_req toggles at T+1.
  - Controller ack seen at T → p_q written at T+1, p_ack toggles at T+2.
  - Earliest next grant is T+3.
- Write transactions leave p_q unchanged.
- A requester must not change its fields or toggle p_req again while pending. The arbiter samples fields only at grant and ignores further p_req activity on the granted port until DONE.
- Ports not granted see no change to their p_ack or p_q.
- All ports pending simultaneously: service order is rr_ptr, rr_ptr+1, ... No port waits more than NUM_PORTS-1 transactions.
- A single port requesting back-to-back is served every 3 cycles plus controller latency; no idle gap is inserted for fairness.
- Reset mid-transaction: the arbiter returns to IDLE immediately and the in-flight request is dropped. Requesters are reset by the same signal.
- Grant index width is fixed at 2 bits (NUM_PORTS ≤ 4). Indices ≥ NUM_PORTS are never produced.

Optional Feature:
- Macro HYPERRAM_ARB_PRIO0_EN.
- Defined: port 0 has fixed highest priority. In IDLE, if pending[0], grant 0 regardless of rr_ptr; rr_ptr is not advanced after a port-0 grant. Ports 1..NUM_PORTS-1 round-robin among themselves.
- Undefined: pure round-robin over all ports as above.

Decomposition:
- Package hyperram_arb_pkg holds:
  - state enum {IDLE, WAIT, DONE};
  - constants ADDR_W=32, DATA_W=16, DS_W=2, MAX_PORTS=4, GRANT_W=2.
- Sub-module hyperram_rr_picker: combinational; inputs pending[NUM_PORTS] and rr_ptr; outputs valid and index. Contains the priority-rotate logic; HYPERRAM_ARB_PRIO0_EN is applied inside it.

Test Plan:
- Single read: port 1 toggles p_req with a=0x00001234, we=0; controller model returns m_q=0xBEEF after 10 cycles → m_a=0x00001234 at T+1, p_q[1]=0xBEEF, p_ack[1] toggles, p_ack[0] and p_ack[2] unchanged.
- Simultaneous requests: ports 0, 1 and 2 toggle in the same cycle with rr_ptr=0 → grants in order 0, 1, 2; after the third completion rr_ptr=0.
- Write passthrough: port 2 writes d=0xA55A, ds=2'b01, as=1 → m_d=0xA55A, m_ds=01, m_as=1 held stable through WAIT; p_q[2] unchanged.
- Stability: change p_a[0] while port 0 is in WAIT → m_a unchanged until DONE.
- Reset mid-WAIT: assert reset asynchronously between edges → m_req, p_ack, busy and grant read 0 before the next clock edge; state is IDLE.
- With HYPERRAM_ARB_PRIO0_EN defined: ports 1 and 2 are saturating and port 0 toggles → port 0 is granted on the next IDLE, ahead of rr_ptr=2.
